// File: rtl/cdc_fifo_wr_packer.sv
// Write-side front end of the async CDC FIFO (w_clk domain).
// Packs RATIO narrow valid/ready lanes into one FIFO word with a per-lane
// keep mask, and pushes completed words to the write-pointer block through
// a one-word output register. An optional almost-full holdoff stops new
// words from starting so a packet is not split across a full condition.
module cdc_fifo_wr_packer #(
    parameter int IN_WIDTH   = 8,
    parameter int RATIO      = 4,
    parameter int AF_HOLDOFF = 1
) (
    input  logic                      w_clk,
    input  logic                      w_rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [IN_WIDTH-1:0]       s_data,
    input  logic                      s_last,
    input  logic                      w_flush,
    input  logic                      w_full,
    input  logic                      w_almost_full,
    output logic                      w_inc,
    output logic [IN_WIDTH*RATIO-1:0] w_data,
    output logic [RATIO-1:0]          w_keep,
    output logic                      w_busy
);

    localparam int DATA_WIDTH = IN_WIDTH * RATIO;
    localparam int LANE_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    // Accumulator: the word currently being filled, or a closed word
    // (acc_done) waiting for the output register to free up.
    logic [DATA_WIDTH-1:0] acc_data;
    logic [RATIO-1:0]      acc_keep;
    logic [LANE_W-1:0]     acc_lane;
    logic                  acc_done;

    // Output register: the word presented to the write-pointer block.
    logic [DATA_WIDTH-1:0] out_data;
    logic [RATIO-1:0]      out_keep;
    logic                  out_valid;

    logic                  holdoff;
    logic                  xfer;
    logic                  accept;
    logic                  close;
    logic                  done_next;
    logic [RATIO-1:0]      lane_onehot;
    logic [RATIO-1:0]      keep_next;

    // Handshake, transfer and word-close decisions for this cycle.
    always_comb begin
        // NOTE: every signal driven here gets a value before any condition,
        // so no path leaves one unassigned and no latch is inferred.
        holdoff     = 1'b0;
        lane_onehot = RATIO'(1) << acc_lane;
        keep_next   = '0;
        close       = 1'b0;
        done_next   = 1'b0;

        // A new word may only be held off before its first lane arrives.
        if (AF_HOLDOFF != 0)
            holdoff = w_almost_full & (acc_keep == '0) & ~acc_done;

        w_inc   = out_valid & ~w_full;
        xfer    = acc_done & (~out_valid | w_inc);
        // Ready is forced low while reset is asserted so nothing is taken
        // into an accumulator that is being cleared.
        s_ready = w_rst_n & (~acc_done | xfer) & ~holdoff;
        accept  = s_valid & s_ready;

        // Keep mask after this cycle: cleared by a transfer, then the
        // accepted lane (if any) added on top.
        keep_next = xfer ? '0 : acc_keep;
        if (accept)
            keep_next = keep_next | lane_onehot;

        close = (accept & ((acc_lane == LAST_LANE) | s_last))
              | (w_flush & (keep_next != '0));
        done_next = (acc_done & ~xfer) | close;
    end

    // Accumulator: write the accepted lane, track fill position and closure.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            // NOTE: the data array is reset too, because w_data must read
            // zero after reset rather than stale contents.
            acc_data <= '0;
            acc_keep <= '0;
            acc_lane <= '0;
            acc_done <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every
            // register samples the pre-edge values computed above.
            if (accept)
                acc_data[acc_lane*IN_WIDTH +: IN_WIDTH] <= s_data;
            acc_keep <= keep_next;
            acc_done <= done_next;
            if (close)
                acc_lane <= '0;
            else if (accept)
                acc_lane <= acc_lane + LANE_W'(1);
        end
    end

    // Output register: load a closed word, drop it once it has been pushed.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_data  <= acc_data;
            out_keep  <= acc_keep;
            out_valid <= 1'b1;
        end else if (w_inc) begin
            out_valid <= 1'b0;
        end
    end

    assign w_data = out_data;
    assign w_keep = out_keep;
    assign w_busy = (acc_keep != '0) | acc_done | out_valid;

endmodule

// File: tb/tb_cdc_fifo_wr_packer.sv
// Self-checking bench for cdc_fifo_wr_packer (IN_WIDTH=8, RATIO=4,
// AF_HOLDOFF=1). A cycle-vector table covers the basic packing cases,
// hand-written sequences cover backpressure, almost-full holdoff and
// mid-word reset, and a random phase is scored against a byte-queue model.
module tb_cdc_fifo_wr_packer;

    localparam int IN_WIDTH = 8;
    localparam int RATIO    = 4;
    localparam int DW       = IN_WIDTH * RATIO;

    logic          w_clk = 1'b0;
    logic          w_rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          s_last;
    logic          w_flush;
    logic          w_full;
    logic          w_almost_full;
    logic          w_inc;
    logic [DW-1:0] w_data;
    logic [3:0]    w_keep;
    logic          w_busy;

    cdc_fifo_wr_packer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO), .AF_HOLDOFF(1)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .w_flush(w_flush), .w_full(w_full), .w_almost_full(w_almost_full),
        .w_inc(w_inc), .w_data(w_data), .w_keep(w_keep), .w_busy(w_busy)
    );

    always #5 w_clk = ~w_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int inc_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] lane_mask(input logic [3:0] k);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < RATIO; i++)
            if (k[i]) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Accepted bytes queue up in cur; a word is formed when RATIO bytes are
    // collected, on s_last, or on a flush with something collected. Words
    // must then appear on w_inc in the same order.
    typedef struct packed {
        logic [DW-1:0] data;
        logic [3:0]    keep;
    } word_t;

    logic [7:0] cur[$];
    word_t      exp_q[$];

    task automatic close_word();
        word_t w;
        w.data = '0;
        w.keep = '0;
        for (int i = 0; i < cur.size(); i++) begin
            w.data[i*8 +: 8] = cur[i];
            w.keep[i]        = 1'b1;
        end
        exp_q.push_back(w);
        cur.delete();
    endtask

    // Scoreboard: sampled on the falling edge, away from the active edge.
    always @(negedge w_clk) begin
        if (!w_rst_n) begin
            cur.delete();
            exp_q.delete();
        end else begin
            if (w_inc) begin
                word_t e;
                inc_count++;
                check("sb_push_while_full", w_full, 1'b0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_push: got w_inc expected no word pending (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_keep", w_keep, e.keep);
                    check("sb_data", w_data & lane_mask(e.keep), e.data);
                end
            end
            if (s_valid && s_ready) begin
                cur.push_back(s_data);
                if (cur.size() == RATIO || s_last) close_word();
            end
            if (w_flush && cur.size() != 0) close_word();
        end
    end

    // ---------------- vector table ----------------
    typedef struct packed {
        logic          v;
        logic [7:0]    d;
        logic          last;
        logic          flush;
        logic          rdy;
        logic          inc;
        logic [3:0]    keep;
        logic [DW-1:0] data;
        logic          busy;
    } vec_t;

    vec_t tbl[16];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int base;
        bit got;

        //            v  data   last flush rdy inc keep   data          busy
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1};
        tbl[4]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1};
        tbl[5]  = '{1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 32'h44332211, 1'b1};
        tbl[6]  = '{1'b1, 8'hCC, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 32'h0000BBAA, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 32'h000000CC, 1'b1};
        tbl[9]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1};
        tbl[11] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'h7, 32'h00030201, 1'b1};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0};

        w_rst_n = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        w_flush = 1'b0;
        w_full = 1'b0;
        w_almost_full = 1'b0;

        // Reset state.
        #2;
        check("rst_ready", s_ready, 1'b0);
        check("rst_inc", w_inc, 1'b0);
        check("rst_keep", w_keep, 4'h0);
        check("rst_busy", w_busy, 1'b0);
        check("rst_data", w_data, '0);
        repeat (3) tick();
        w_rst_n = 1'b1;

        // Table: full word, short packets, flush, empty flush.
        for (int i = 0; i < 16; i++) begin
            s_valid = tbl[i].v;
            s_data  = tbl[i].d;
            s_last  = tbl[i].last;
            w_flush = tbl[i].flush;
            #1;
            check($sformatf("tbl%0d_ready", i), s_ready, tbl[i].rdy);
            check($sformatf("tbl%0d_inc", i), w_inc, tbl[i].inc);
            check($sformatf("tbl%0d_busy", i), w_busy, tbl[i].busy);
            if (tbl[i].inc) begin
                check($sformatf("tbl%0d_keep", i), w_keep, tbl[i].keep);
                check($sformatf("tbl%0d_data", i), w_data & lane_mask(tbl[i].keep), tbl[i].data);
            end
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0; w_flush = 1'b0;

        // Backpressure: w_full held, 12 bytes offered; only 8 fit.
        w_full = 1'b1;
        idx = 0;
        base = inc_count;
        for (int c = 0; c < 20; c++) begin
            s_valid = (idx < 12);
            s_data  = 8'h50 + 8'(idx);
            #1;
            if (s_valid && s_ready) idx++;
            tick();
        end
        check("bp_accepted_while_full", idx, 8);
        check("bp_no_inc_while_full", inc_count - base, 0);
        #1;
        check("bp_ready_low", s_ready, 1'b0);
        w_full = 1'b0;
        for (int c = 0; c < 30; c++) begin
            s_valid = (idx < 12);
            s_data  = 8'h50 + 8'(idx);
            #1;
            if (s_valid && s_ready) idx++;
            tick();
        end
        s_valid = 1'b0;
        check("bp_accepted_total", idx, 12);
        check("bp_inc_total", inc_count - base, 3);

        // Almost-full holdoff: raised mid-word, the word still completes.
        base = inc_count;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data = 8'hA0 + 8'(i);
            w_almost_full = (i >= 2);
            #1;
            check($sformatf("af_midword_ready%0d", i), s_ready, 1'b1);
            tick();
        end
        s_valid = 1'b0;
        repeat (4) tick();
        check("af_midword_pushed", inc_count - base, 1);
        // At a word boundary the new word is held off until it drops.
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data = 8'hB0;
            s_last = 1'b1;
            #1;
            check($sformatf("af_boundary_ready%0d", i), s_ready, 1'b0);
            tick();
        end
        w_almost_full = 1'b0;
        #1;
        check("af_release_ready", s_ready, 1'b1);
        tick();
        s_valid = 1'b0;
        s_last = 1'b0;
        repeat (4) tick();

        // Reset mid-word: two bytes in, then reset.
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_data = 8'hE1 + 8'(i);
            tick();
        end
        s_valid = 1'b0;
        #1;
        check("mid_busy_before_rst", w_busy, 1'b1);
        w_rst_n = 1'b0;
        #1;
        check("mid_rst_inc", w_inc, 1'b0);
        check("mid_rst_keep", w_keep, 4'h0);
        check("mid_rst_busy", w_busy, 1'b0);
        check("mid_rst_ready", s_ready, 1'b0);
        repeat (2) tick();
        w_rst_n = 1'b1;
        #1;
        check("post_rst_ready", s_ready, 1'b1);
        check("post_rst_busy", w_busy, 1'b0);
        check("post_rst_data", w_data, '0);
        tick();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data = 8'hF1 + 8'(i);
            tick();
        end
        s_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            #1;
            if (w_inc) begin
                got = 1'b1;
                check("post_rst_keep", w_keep, 4'hF);
                check("post_rst_word", w_data, 32'hF4F3F2F1);
            end
            tick();
        end
        check("post_rst_word_seen", got, 1'b1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            s_data = 8'($urandom);
            s_last = ($urandom_range(0, 6) == 0);
            w_flush = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) w_full = ~w_full;
            w_almost_full = ($urandom_range(0, 4) == 0);
            tick();
        end

        // Drain: close any partial word and let everything push.
        s_valid = 1'b0; s_last = 1'b0;
        w_full = 1'b0; w_almost_full = 1'b0;
        w_flush = 1'b1;
        tick();
        w_flush = 1'b0;
        for (int c = 0; c < 20 && w_busy; c++) tick();
        repeat (2) tick();
        check("drain_busy", w_busy, 1'b0);
        check("drain_words_left", exp_q.size(), 0);
        check("drain_bytes_left", cur.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
